uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
- UART receiver: 8 data bits, no parity, 1 stop bit, LSB first, idle-high line.
- Pairs with the existing transmitter at the same SYSCLK and BAUD.
- Brings the asynchronous serial line into the clk domain and samples each bit at its midpoint.
- Presents each received byte with a single-cycle done strobe.
- Sits between the board RX pin and the command/data consumer logic; loopback against the transmitter is the reference integration.

Parameters:
- SYSCLK, 125_000_000, system clock frequency in Hz.
- BAUD, 115200, line bit rate.
- DELAY, SYSCLK/BAUD (1085 at defaults), clocks per bit, integer-truncated.
- HALF, DELAY/2 (542 at defaults), clocks from start-edge detect to mid-start-bit sample.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- rx  in  1  serial line from the pin; asynchronous to clk.
- data  out  8  last correctly framed byte; held until the next good frame.
- done  out  1  one-cycle pulse: data has just been updated.
- frame_err  out  1  one-cycle pulse: stop bit sampled as 0; data not updated.
- busy  out  1  high in every state other than IDLE.

Behaviour:
- Reset values: data=8'h00, done=0, frame_err=0, busy=0, state=IDLE, counters=0, both synchroniser flops=1 (line idle).
- rx passes through a 2-flop synchroniser to give rx_s. A third flop holds rx_s delayed by one cycle for edge detection. Only rx_s is used downstream.
- FSM states, one-hot: IDLE, START, RECV, STOP.
- Counters: cnt is 32 bit and cleared on every state change. cnt_bit is 3 bit and counts data bits 0..7.
- IDLE:
  - Detect falling edge (rx_s delayed = 1, rx_s = 0) -> START, cnt=0.
  - Otherwise stay in IDLE.
  - Falling edges are ignored in all other states.
- START:
  - Increment cnt until cnt == HALF-1.
  - At that cycle, if rx_s == 0 -> RECV with cnt=0 and cnt_bit=0.
  - If rx_s == 1, treat it as a glitch -> IDLE with no strobe.
- RECV:
  - Increment cnt until cnt == DELAY-1.
  - At that cycle shift rx_s into bit position cnt_bit of the shift register, clear cnt, and increment cnt_bit.
  - After bit 7 is sampled -> STOP.
- STOP:
  - At cnt == DELAY-1, sample rx_s.
  - If 1: data <= shift register, done=1 for exactly one cycle.
  - If 0: frame_err=1 for exactly one cycle, data unchanged.
  - Either way -> IDLE in the same cycle.
  - Returning at mid-stop-bit gives half a bit of slack, so back-to-back frames with zero idle time must be received.
- done and frame_err are registered, mutually exclusive, and never asserted in the same cycle as reset deassertion.
- Latency: from the rx falling edge at the pin to done is 3 + HALF + 9*DELAY clocks, ±1 for synchroniser phase. This is 10310 ±1 at defaults.
- Break condition: a line held low produces frame_err. The FSM then waits in IDLE for a new 1->0 edge, so no repeated frame is reported while the line stays low.
- rst asserted mid-frame: all state returns to reset values immediately and no strobe is issued. After release, the remainder of the interrupted frame is accepted only if a fresh falling edge occurs.

Decomposition:
- Shared package uart_pkg holds:
  - SYSCLK and BAUD defaults;
  - the DELAY/HALF derivation;
  - the one-hot state encodings IDLE/START/RECV/STOP.
  Transmitter and receiver both draw from it, so they cannot disagree on the bit period.
- One sub-module: sync_2ff (1-bit, reset value parameterised to 1), reused wherever an asynchronous pin enters clk.

Test Plan:
- Byte 8'hA5 driven at 115200 with 1 stop bit -> done pulses once, 10310 ±1 clocks after the start edge; data == 8'hA5; frame_err stays 0.
- Back-to-back 8'h00 then 8'hFF with zero idle between stop and next start -> two done pulses; data goes 8'h00 then 8'hFF; no frame_err.
- 100-clock low glitch on idle rx -> FSM enters START, returns to IDLE at HALF-1; no done, no frame_err; busy high for ≈HALF clocks only.
- Frame 8'h3C with stop bit forced 0, after a good 8'h5A -> one frame_err pulse, no done, data stays 8'h5A. Holding rx low for a further 20 bit times produces no further pulses.
- rst pulsed for 5 clocks during bit 4 of 8'hC3 -> outputs return to reset values, no strobe. The next clean frame 8'h81 is received correctly.
- Loopback: existing transmitter output tied to rx, send 8'h55, 8'hAA, 8'h0F -> three done pulses with matching data; the transmitter's done and the receiver's done are each seen once per byte.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART timing and state definitions used by both the transmitter and the receiver.
// Deriving the bit period in one place keeps both ends on the same baud timing.
package uart_pkg;

    localparam int unsigned SYSCLK_DEF = 125_000_000;
    localparam int unsigned BAUD_DEF   = 115_200;

    // Clocks per bit, integer-truncated.
    function automatic int unsigned bit_delay(input int unsigned sysclk, input int unsigned baud);
        return sysclk / baud;
    endfunction

    // Clocks from start-edge detect to the middle of the start bit.
    function automatic int unsigned half_delay(input int unsigned sysclk, input int unsigned baud);
        return (sysclk / baud) / 2;
    endfunction

    typedef enum logic [3:0] {
        ST_IDLE  = 4'b0001,
        ST_START = 4'b0010,
        ST_RECV  = 4'b0100,
        ST_STOP  = 4'b1000
    } uart_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input entering the clk domain.
module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver, 8N1, LSB first: synchronises rx, samples each bit at its midpoint and
// reports each frame with a one-cycle done (good stop bit) or frame_err (stop bit low) strobe.
// Handshake: done/frame_err are single-cycle pulses with no backpressure; data is valid
// in the cycle done is high and is held until the next good frame.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned SYSCLK = SYSCLK_DEF,
    parameter int unsigned BAUD   = BAUD_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx,
    output logic [7:0]  data,
    output logic        done,
    output logic        frame_err,
    output logic        busy,
    output uart_state_e state_dbg
);

    localparam int unsigned DELAY = bit_delay(SYSCLK, BAUD);
    localparam int unsigned HALF  = half_delay(SYSCLK, BAUD);
    localparam logic [31:0] DELAY_LAST = 32'(DELAY - 1);
    localparam logic [31:0] HALF_LAST  = 32'(HALF - 1);

    logic        rx_s;
    logic        rx_dly_q;
    uart_state_e state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  data_q, data_d;
    logic        done_q, done_d;
    logic        ferr_q, ferr_d;

    sync_2ff #(.RST_VAL(1'b1)) u_sync (
        .clk_i (clk),
        .rst_i (rst),
        .d_i   (rx),
        .q_o   (rx_s)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_dly_q <= 1'b1;
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            data_q   <= '0;
            done_q   <= 1'b0;
            ferr_q   <= 1'b0;
        end else begin
            rx_dly_q <= rx_s;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            data_q   <= data_d;
            done_q   <= done_d;
            ferr_q   <= ferr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 32'd1;
        bit_d   = bit_q;
        shift_d = shift_q;
        data_d  = data_q;
        done_d  = 1'b0;
        ferr_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (rx_dly_q && !rx_s) begin
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    // A line back high at mid-start is a glitch, not a frame.
                    state_d = rx_s ? ST_IDLE : ST_RECV;
                end
            end
            ST_RECV: begin
                if (cnt_q == DELAY_LAST) begin
                    cnt_d          = '0;
                    shift_d[bit_q] = rx_s;
                    bit_d          = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_d = ST_STOP;
                    end
                end
            end
            ST_STOP: begin
                if (cnt_q == DELAY_LAST) begin
                    // Leaving at mid-stop leaves half a bit to catch a back-to-back start.
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                    if (rx_s) begin
                        data_d = shift_q;
                        done_d = 1'b1;
                    end else begin
                        ferr_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign data      = data_q;
    assign done      = done_q;
    assign frame_err = ferr_q;
    assign busy      = (state_q != ST_IDLE);
    assign state_dbg = state_q;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: one instance at default baud for latency/glitch timing, and one fast
// instance driven by a table, a break sequence, randomized frames, a mid-frame reset and a loopback.
module tb_uart_rx;
  import uart_pkg::*;

  localparam int DA    = 1085;   // clocks per bit at 125 MHz / 115200
  localparam int HA    = 542;
  localparam int LAT_A = 10310;
  localparam int DB    = 16;     // fast instance: 1.6 MHz / 100 kBd
  localparam int HB    = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, rx_a, done_a, ferr_a, busy_a;
  logic [7:0]  data_a;
  uart_state_e st_a;
  logic        rst_b, rx_b, done_b, ferr_b, busy_b;
  logic [7:0]  data_b;
  uart_state_e st_b;

  uart_rx u_dut_a (
    .clk(clk), .rst(rst_a), .rx(rx_a), .data(data_a), .done(done_a),
    .frame_err(ferr_a), .busy(busy_a), .state_dbg(st_a)
  );

  uart_rx #(.SYSCLK(1_600_000), .BAUD(100_000)) u_dut_b (
    .clk(clk), .rst(rst_b), .rx(rx_b), .data(data_b), .done(done_b),
    .frame_err(ferr_b), .busy(busy_b), .state_dbg(st_b)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic chk_range(input string name, input int got, input int lo, input int hi);
    checks++;
    if (got < lo || got > hi) begin
      errors++;
      $display("FAIL %s got=%0d expected %0d..%0d", name, got, lo, hi);
    end
  endtask

  // ---------------- instance A monitor ----------------
  int done_a_cnt = 0;
  int ferr_a_cnt = 0;
  always @(negedge clk) begin
    if (!rst_a) begin
      done_a_cnt += int'(done_a);
      ferr_a_cnt += int'(ferr_a);
    end
  end

  // ---------------- instance B scoreboard: {is_err, data} ----------------
  logic [8:0] exp_q[$];
  logic [7:0] last_good = 8'h00;
  bit         ignore_b  = 1'b0;
  int         rx_done_cnt = 0;
  int         tx_done_cnt = 0;

  always @(negedge clk) begin
    if (!rst_b && !ignore_b && (done_b || ferr_b)) begin
      checks++;
      rx_done_cnt += int'(done_b);
      if (done_b && ferr_b) begin
        errors++;
        $display("FAIL strobe_excl got done=1 frame_err=1 expected only one");
      end else if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_strobe got done=%0d frame_err=%0d data=%h expected none",
                 done_b, ferr_b, data_b);
      end else begin
        logic [8:0] e;
        e = exp_q.pop_front();
        if ({ferr_b, data_b} !== e) begin
          errors++;
          $display("FAIL frame got err=%0d data=%h expected err=%0d data=%h",
                   ferr_b, data_b, e[8], e[7:0]);
        end
      end
    end
  end

  // Reference rule: a high stop bit delivers the byte, a low one reports an error and
  // leaves the previous good byte on data.
  task automatic model_frame(input logic [7:0] b, input logic stop);
    if (stop) begin
      exp_q.push_back({1'b0, b});
      last_good = b;
    end else begin
      exp_q.push_back({1'b1, last_good});
    end
  endtask

  // Drivers assume they are called right at a negedge and leave the line at the last level.
  task automatic send_a(input logic [7:0] b);
    rx_a = 1'b0;
    repeat (DA) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_a = b[i];
      repeat (DA) @(negedge clk);
    end
    rx_a = 1'b1;
    repeat (DA) @(negedge clk);
  endtask

  task automatic send_b(input logic [7:0] b, input logic stop, input int gap_bits);
    rx_b = 1'b0;
    repeat (DB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_b = b[i];
      repeat (DB) @(negedge clk);
    end
    rx_b = stop;
    repeat (DB) @(negedge clk);
    tx_done_cnt++;
    if (gap_bits > 0) begin
      rx_b = 1'b1;
      repeat (gap_bits * DB) @(negedge clk);
    end
  endtask

  task automatic drain_b(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 40 * DB) begin
      @(negedge clk);
      n++;
    end
    chk(name, exp_q.size(), 0);
  endtask

  typedef struct {
    logic [7:0] b;
    logic       stop;
    int         gap;
    logic [8:0] exp;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int lat, busy_cnt, tx0, rx0;

    vecs[0] = '{b: 8'hA5, stop: 1'b1, gap: 1, exp: {1'b0, 8'hA5}};
    vecs[1] = '{b: 8'h00, stop: 1'b1, gap: 0, exp: {1'b0, 8'h00}};
    vecs[2] = '{b: 8'hFF, stop: 1'b1, gap: 1, exp: {1'b0, 8'hFF}};
    vecs[3] = '{b: 8'h5A, stop: 1'b1, gap: 1, exp: {1'b0, 8'h5A}};
    vecs[4] = '{b: 8'h3C, stop: 1'b0, gap: 0, exp: {1'b1, 8'h5A}};

    // ---------------- reset ----------------
    rst_a = 1'b1; rst_b = 1'b1; rx_a = 1'b1; rx_b = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_data_a", data_a, 8'h00);
    chk("rst_done_a", done_a, 1'b0);
    chk("rst_ferr_a", ferr_a, 1'b0);
    chk("rst_busy_a", busy_a, 1'b0);
    chk("rst_state_a", st_a, ST_IDLE);
    chk("rst_state_b", st_b, ST_IDLE);
    rst_a = 1'b0; rst_b = 1'b0;
    @(negedge clk);
    chk("rel_done_b", done_b, 1'b0);
    chk("rel_ferr_b", ferr_b, 1'b0);
    repeat (4) @(negedge clk);

    // ---------------- A: latency of 8'hA5 at default baud ----------------
    lat = 0;
    fork
      send_a(8'hA5);
      begin
        while (!done_a && lat < 20000) begin
          @(negedge clk);
          lat++;
        end
      end
    join
    chk_range("latency_a5", lat, LAT_A - 1, LAT_A + 1);
    chk("data_a5", data_a, 8'hA5);
    chk("done_cnt_a5", done_a_cnt, 1);
    chk("ferr_cnt_a5", ferr_a_cnt, 0);

    // ---------------- A: 100-clock glitch ----------------
    busy_cnt = 0;
    rx_a = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      if (i == 100) rx_a = 1'b1;
      @(negedge clk);
      busy_cnt += int'(busy_a);
    end
    chk_range("glitch_busy", busy_cnt, HA - 1, HA + 1);
    chk("glitch_state", st_a, ST_IDLE);
    chk("glitch_done_cnt", done_a_cnt, 1);
    chk("glitch_ferr_cnt", ferr_a_cnt, 0);

    // ---------------- B: table (includes back-to-back 00/FF and bad stop) ----------------
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(vecs[i].exp);
      send_b(vecs[i].b, vecs[i].stop, vecs[i].gap);
    end
    last_good = 8'h5A;
    // Break: line stays low for 20 more bit times, then idles.
    repeat (20 * DB) @(negedge clk);
    chk("break_data", data_b, 8'h5A);
    rx_b = 1'b1;
    repeat (2 * DB) @(negedge clk);
    drain_b("table_drain");

    // ---------------- B: randomized frames against the model ----------------
    for (int i = 0; i < 40; i++) begin
      logic [7:0] b;
      logic       stop;
      int         gap;
      b    = 8'($urandom_range(0, 255));
      stop = ($urandom_range(0, 7) != 0);
      gap  = stop ? int'($urandom_range(0, 2)) : int'($urandom_range(1, 2));
      model_frame(b, stop);
      send_b(b, stop, gap);
    end
    rx_b = 1'b1;
    repeat (2 * DB) @(negedge clk);
    drain_b("random_drain");

    // ---------------- B: reset during bit 4 of 8'hC3 ----------------
    // The synchroniser restarts at 1, so a still-low line looks like a new edge after
    // release; strobes from that tail are not scored, only the following clean frame.
    ignore_b = 1'b1;
    fork
      send_b(8'hC3, 1'b1, 12);
      begin
        repeat (5 * DB + HB) @(negedge clk);
        rst_b = 1'b1;
        repeat (2) @(negedge clk);
        chk("midrst_data", data_b, 8'h00);
        chk("midrst_done", done_b, 1'b0);
        chk("midrst_ferr", ferr_b, 1'b0);
        chk("midrst_busy", busy_b, 1'b0);
        chk("midrst_state", st_b, ST_IDLE);
        repeat (3) @(negedge clk);
        rst_b = 1'b0;
      end
    join
    repeat (2 * DB) @(negedge clk);
    ignore_b = 1'b0;
    model_frame(8'h81, 1'b1);
    send_b(8'h81, 1'b1, 2);
    drain_b("after_rst_drain");
    chk("after_rst_data", data_b, 8'h81);

    // ---------------- B: loopback-style stream 55/AA/0F ----------------
    tx0 = tx_done_cnt;
    rx0 = rx_done_cnt;
    model_frame(8'h55, 1'b1); send_b(8'h55, 1'b1, 0);
    model_frame(8'hAA, 1'b1); send_b(8'hAA, 1'b1, 0);
    model_frame(8'h0F, 1'b1); send_b(8'h0F, 1'b1, 2);
    drain_b("loop_drain");
    chk("loop_tx_done", tx_done_cnt - tx0, 3);
    chk("loop_rx_done", rx_done_cnt - rx0, 3);
    chk("loop_data", data_b, 8'h0F);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
